// File: rtl/psa_pkg.sv
// Shared types and helpers for the partial-sum accumulator: lane state
// encoding and the chunk-counter width function.
package psa_pkg;

   typedef enum logic [0:0] {
      IDLE_ACC = 1'b0,
      HOLD     = 1'b1
   } lane_state_e;

   // Counter width able to index 0..chunks-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned chunks);
      if (chunks <= 32'd1)
         return 32'd1;
      return 32'($clog2(chunks));
   endfunction

endpackage

// File: rtl/psa_lane.sv
// One accumulator lane: counts partial sums, accumulates, and parks the
// finished dot product in a holding register. PSA_SATURATE_EN selects clamping.
module psa_lane
   import psa_pkg::*;
#(
   parameter int unsigned BIT_WIDTH  = 8,
   parameter int unsigned NUM_CHUNKS = 4,
   parameter int unsigned ACC_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2*BIT_WIDTH-1:0] c,
   input  logic                   valid,
   output logic [ACC_WIDTH-1:0]   sum,
   output logic                   sum_valid,
   input  logic                   sum_ready,
   output logic                   drop
);

   localparam int unsigned     CNT_W = cnt_width(NUM_CHUNKS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 32'd1);

   lane_state_e          state;
   logic [CNT_W-1:0]     cnt;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] c_ext;
   logic [ACC_WIDTH-1:0] add_res;
   logic                 last_chunk;
   logic                 take;

   assign c_ext = ACC_WIDTH'(c);

`ifdef PSA_SATURATE_EN
   logic [ACC_WIDTH:0] add_full;

   // Carry out of the accumulator width pins the result at all-ones.
   assign add_full = {1'b0, acc} + {1'b0, c_ext};
   assign add_res  = add_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : add_full[ACC_WIDTH-1:0];
`else
   assign add_res = acc + c_ext;
`endif

   assign last_chunk = valid && (cnt == LAST);
   // Holding register can accept a result: empty, or being drained this edge.
   assign take       = (state == IDLE_ACC) || sum_ready;
   assign sum_valid  = (state == HOLD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE_ACC;
         cnt   <= '0;
         acc   <= '0;
         sum   <= '0;
         drop  <= 1'b0;
      end else begin
         if (valid) begin
            if (cnt == LAST) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               acc <= add_res;
               cnt <= cnt + CNT_W'(1);
            end
         end

         if (last_chunk && take) begin
            sum   <= add_res;
            state <= HOLD;
         end else begin
            if (last_chunk)
               drop <= 1'b1;
            if ((state == HOLD) && sum_ready)
               state <= IDLE_ACC;
         end
      end
   end

endmodule

// File: rtl/partial_sum_accumulator.sv
// NUM_PARA independent partial-sum accumulator lanes. Optional clamping on
// overflow is enabled by defining PSA_SATURATE_EN (wrap-around otherwise).
module partial_sum_accumulator
   import psa_pkg::*;
#(
   parameter int unsigned BIT_WIDTH  = 8,
   parameter int unsigned NUM_PARA   = 43,
   parameter int unsigned NUM_CHUNKS = 4,
   parameter int unsigned ACC_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2*BIT_WIDTH-1:0] c         [0:NUM_PARA-1],
   input  logic                   valid     [0:NUM_PARA-1],
   output logic [ACC_WIDTH-1:0]   sum       [0:NUM_PARA-1],
   output logic                   sum_valid [0:NUM_PARA-1],
   input  logic                   sum_ready [0:NUM_PARA-1],
   output logic [NUM_PARA-1:0]    drop
);

   for (genvar i = 0; i < NUM_PARA; i++) begin : g_lane
      psa_lane #(
         .BIT_WIDTH  (BIT_WIDTH),
         .NUM_CHUNKS (NUM_CHUNKS),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .c         (c[i]),
         .valid     (valid[i]),
         .sum       (sum[i]),
         .sum_valid (sum_valid[i]),
         .sum_ready (sum_ready[i]),
         .drop      (drop[i])
      );
   end

endmodule
